// File: rtl/ascensor_pkg.sv
// Shared elevator types: scan states, motion codes, floors, button codes.
// Floor helpers map button codes to the floor that serves them.
package ascensor_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2
  } dir_e;

  localparam logic [1:0] PARADO = 2'd0;
  localparam logic [1:0] SUBE   = 2'd1;
  localparam logic [1:0] BAJA   = 2'd2;

  localparam logic [1:0] P1 = 2'd0;
  localparam logic [1:0] P2 = 2'd1;
  localparam logic [1:0] P3 = 2'd2;
  localparam logic [1:0] P4 = 2'd3;

  localparam logic [3:0] B_NINGUNO = 4'd0;
  localparam logic [3:0] B_C1      = 4'd1;
  localparam logic [3:0] B_C2      = 4'd2;
  localparam logic [3:0] B_C3      = 4'd3;
  localparam logic [3:0] B_C4      = 4'd4;
  localparam logic [3:0] B_P1_SUBE = 4'd5;
  localparam logic [3:0] B_P2_BAJA = 4'd6;
  localparam logic [3:0] B_P2_SUBE = 4'd7;
  localparam logic [3:0] B_P3_BAJA = 4'd8;
  localparam logic [3:0] B_P3_SUBE = 4'd9;
  localparam logic [3:0] B_P4_BAJA = 4'd10;

  typedef struct packed {
    logic       valido;
    logic [1:0] piso;
  } cod_piso_t;

  function automatic cod_piso_t codigo_a_piso(input logic [3:0] codigo);
    cod_piso_t r;
    r.valido = 1'b1;
    case (codigo)
      B_C1, B_P1_SUBE:            r.piso = P1;
      B_C2, B_P2_BAJA, B_P2_SUBE: r.piso = P2;
      B_C3, B_P3_BAJA, B_P3_SUBE: r.piso = P3;
      B_C4, B_P4_BAJA:            r.piso = P4;
      default: begin
        r.valido = 1'b0;
        r.piso   = P1;
      end
    endcase
    return r;
  endfunction

  // Pending-vector bits owned by each floor.
  function automatic logic [9:0] mascara_piso(input logic [1:0] p);
    logic [9:0] m;
    m = '0;
    for (int i = 1; i <= 10; i++) begin
      if (codigo_a_piso(4'(i)).piso == p)
        m[i-1] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/filtro_rebote.sv
// Two-flop synchronizer plus stability counter for the 4-bit button code.
// Only built with FILTRO_REBOTE_EN.
`ifdef FILTRO_REBOTE_EN
module filtro_rebote #(
  parameter int CICLOS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] entrada,
  output logic [3:0] salida
);

  localparam int CW = $clog2(CICLOS + 1);
  localparam logic [CW-1:0] LIM_SAT = CW'(CICLOS - 1);
  // The window starts on the edge the change lands in r_s2.
  localparam logic [CW-1:0] LIM_SAL = CW'(CICLOS - 2);

  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_sal;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_sal <= '0;
      r_cnt <= '0;
    end else if (en) begin
      r_s1 <= entrada;
      r_s2 <= r_s1;
      if (r_s1 != r_s2) begin
        r_cnt <= '0;
      end else begin
        if (r_cnt != LIM_SAT)
          r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LIM_SAL)
          r_sal <= r_s2;
      end
    end
  end

  assign salida = r_sal;

endmodule
`endif

// File: rtl/gestor_solicitudes.sv
// Elevator request manager: button capture, service clear, SCAN targeting.
// FILTRO_REBOTE_EN adds a debounce filter on the button input.
module gestor_solicitudes
  import ascensor_pkg::*;
#(
  parameter int CICLOS_REBOTE = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] boton_pres,
  input  logic       obtener,
  input  logic [1:0] piso,
  input  logic [1:0] accion,
  input  logic       puertas,
  output logic [3:0] memoria,
  output logic [9:0] pendientes,
  output logic [1:0] direccion
);

  logic [3:0] w_b;
  logic [3:0] r_bprev;
  logic [9:0] r_pend;
  logic [3:0] r_mem;
  dir_e       r_dir;
  dir_e       w_dir_sig;

`ifdef FILTRO_REBOTE_EN
  filtro_rebote #(
    .CICLOS (CICLOS_REBOTE)
  ) u_filtro (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .entrada (boton_pres),
    .salida  (w_b)
  );
`else
  logic [3:0] r_b;
  logic       w_unused_ciclos;

  assign w_unused_ciclos = (CICLOS_REBOTE != 0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_b <= '0;
    else if (en)
      r_b <= boton_pres;
  end

  assign w_b = r_b;
`endif

  logic [9:0] w_set;
  logic [9:0] w_clr;
  logic [3:0] w_dem;
  logic       w_arriba;
  logic       w_abajo;
  logic       w_sube_ok;
  logic       w_baja_ok;
  logic [1:0] w_sube;
  logic [1:0] w_baja;
  logic [1:0] w_obj;

  always_comb begin
    w_set = '0;
    if (w_b != r_bprev && codigo_a_piso(w_b).valido)
      for (int i = 0; i < 10; i++)
        w_set[i] = (w_b == 4'(i + 1));
    w_clr = '0;
    if (puertas && accion == PARADO)
      w_clr = mascara_piso(piso);
    for (int f = 0; f < 4; f++)
      w_dem[f] = |(r_pend & mascara_piso(2'(f)));
  end

  // Nearest demand at or above / at or below the cabin.
  always_comb begin
    w_arriba  = 1'b0;
    w_abajo   = 1'b0;
    w_sube_ok = 1'b0;
    w_baja_ok = 1'b0;
    w_sube    = '0;
    w_baja    = '0;
    for (int f = 3; f >= 0; f--) begin
      if (w_dem[f] && 2'(f) >= piso) begin
        w_sube_ok = 1'b1;
        w_sube    = 2'(f);
      end
    end
    for (int f = 0; f < 4; f++) begin
      if (w_dem[f] && 2'(f) <= piso) begin
        w_baja_ok = 1'b1;
        w_baja    = 2'(f);
      end
      if (w_dem[f] && 2'(f) > piso)
        w_arriba = 1'b1;
      if (w_dem[f] && 2'(f) < piso)
        w_abajo = 1'b1;
    end
  end

  always_comb begin
    w_dir_sig = r_dir;
    w_obj     = w_sube_ok ? w_sube : w_baja;
    unique case (1'b1)
      (r_dir == SUBIENDO): begin
        if (!w_sube_ok)
          w_dir_sig = w_abajo ? BAJANDO : REPOSO;
      end
      (r_dir == BAJANDO): begin
        w_obj = w_baja_ok ? w_baja : w_sube;
        if (!w_baja_ok)
          w_dir_sig = w_arriba ? SUBIENDO : REPOSO;
      end
      default: begin
        if (w_dem[piso])
          w_dir_sig = REPOSO;
        else if (w_arriba)
          w_dir_sig = SUBIENDO;
        else if (w_abajo)
          w_dir_sig = BAJANDO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bprev <= '0;
      r_pend  <= '0;
      r_mem   <= '0;
      r_dir   <= REPOSO;
    end else if (en) begin
      r_bprev <= w_b;
      r_pend  <= (r_pend | w_set) & ~w_clr;
      r_dir   <= w_dir_sig;
      if (obtener)
        r_mem <= (w_dem == 4'd0) ? 4'd0 : {2'b00, w_obj} + 4'd1;
    end
  end

  assign memoria    = r_mem;
  assign pendientes = r_pend;
  assign direccion  = r_dir;

endmodule

// File: doc/gestor_solicitudes.md
# gestor_solicitudes

Request manager of the elevator controller, sitting directly upstream of the floor state machine. Captures button codes 1–10 from `boton_pres`, keeps them pending until served, and on each `obtener` pulse hands the state machine the next target floor as a cabin code 1–4 on `memoria`, or 0 if nothing is pending. Uses a collective up/down (SCAN) policy driven by the current floor, motion and door status reported back by the state machine.

## Interface
Parameters:
- `CICLOS_REBOTE`, 1000000: input stability window in clk cycles. Used only with `FILTRO_REBOTE_EN`.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: enable; low freezes all registers except under reset.
- `boton_pres` in 4: raw button code. 0 = none; 1–4 = cabin floor 1–4; 5 = floor 1 up; 6/7 = floor 2 down/up; 8/9 = floor 3 down/up; 10 = floor 4 down; 11–15 ignored.
- `obtener` in 1: fetch strobe from the state machine.
- `piso` in 2: current floor, 0–3.
- `accion` in 2: motion; 0 = stopped, 1 = up, 2 = down.
- `puertas` in 1: 1 = doors open.
- `memoria` out 4: next target, cabin code 1–4, or 0.
- `pendientes` out 10: bit i-1 set = code i pending.
- `direccion` out 2: scan state; 0 = REPOSO, 1 = SUBIENDO, 2 = BAJANDO.

## Operation
- Floor demand `dem[3:0]` is the OR of pending codes per floor:
  - floor 0: codes 1, 5
  - floor 1: codes 2, 6, 7
  - floor 2: codes 3, 8, 9
  - floor 3: codes 4, 10
- Capture:
  - Sampled code `b` (filtered or raw) is compared with its registered previous value `b_prev`.
  - When `b` differs from `b_prev` and `b` is 1–10, set `pendientes[b-1]`.
  - A held button registers once. Re-pressing the same code is a no-op while it is pending.
- Service clear: while `puertas==1 && accion==0`, clear every code belonging to floor `piso` on each enabled edge.
- Simultaneous capture and clear of the same floor: clear wins; the request is already served.
- Scan FSM; `arriba` = any `dem` above `piso`, `abajo` = any `dem` below `piso`:
  - REPOSO: if `dem[piso]`, target = `piso` and stay. Else if `arriba`, go to SUBIENDO. Else if `abajo`, go to BAJANDO.
  - SUBIENDO: target = lowest floor ≥ `piso` with demand. If none and `abajo`, go to BAJANDO. If none and not `abajo`, go to REPOSO.
  - BAJANDO: mirror of SUBIENDO (highest floor ≤ `piso` with demand; fall back to SUBIENDO, then REPOSO).
  - The FSM updates every enabled cycle, independent of `obtener`.
- `memoria` encoding: target floor + 1, or 0 if `dem==0`. It is updated only on an edge where `obtener==1`, otherwise held.

## Timing
- Reset values: `pendientes=0`, `memoria=0`, `direccion=REPOSO`, `b_prev=0`, debounce counter 0.
- Press latency to `pendientes`:
  - Without filter: 2 edges (input register, then edge detect).
  - With filter: `CICLOS_REBOTE`+2 edges.
- `obtener` latency: `memoria` is valid the edge after `obtener` is sampled high.
  - The value reflects `pendientes` and the FSM state as of that edge; a same-cycle capture is not visible.
  - A multi-cycle `obtener` refreshes `memoria` every cycle.
- `en==0`: no capture, no clear, no FSM move, `memoria` held; `obtener` is ignored.
- Reset mid-operation: all pending requests are discarded immediately (asynchronous).

## Configuration
- `FILTRO_REBOTE_EN` defined:
  - `boton_pres` passes through a 2-flop synchronizer and a stability counter.
  - `b` updates only after the synchronized value has been unchanged for `CICLOS_REBOTE` consecutive cycles.
  - Any change restarts the count.
- Not defined: `b` is `boton_pres` through a single register; `CICLOS_REBOTE` is unused.

## Structure
- Shared package `ascensor_pkg` holds:
  - the scan state enum (REPOSO/SUBIENDO/BAJANDO);
  - accion constants (PARADO=0, SUBE=1, BAJA=2);
  - floor constants P1–P4;
  - button code constants;
  - function `codigo_a_piso(code) -> 2-bit floor` (valid flag for 1–10).
- One sub-module, `filtro_rebote`: synchronizer plus stability counter, 4-bit wide. Instantiated only under `FILTRO_REBOTE_EN`.

## Test plan
- Reset, then press code 3 for 5 cycles, then 0, with `piso=0`: `pendientes=10'b0000000100` (set once). After `obtener`: `memoria=3`, `direccion=SUBIENDO`.
- Pending codes 2 and 10 (`dem` = floors 1 and 3), `piso=0`, SUBIENDO: `obtener` gives `memoria=2`. Then doors open at `piso=1`: code 2 cleared, and the next `obtener` gives `memoria=4`.
- `piso=2`, BAJANDO, pending code 5 only: `obtener` gives `memoria=1`. Then `piso=0` with doors open clears it, `direccion` returns to REPOSO, and the next `obtener` gives `memoria=0`.
- Doors open at `piso=1` while `boton_pres=7` is pressed: bit 6 stays 0. Code 11 is pressed: `pendientes` unchanged.
- `en=0` with a press and `obtener=1`: `pendientes` and `memoria` unchanged. Assert `rst` low mid-run with 4 codes pending: all outputs return to 0/REPOSO without a clock edge.
- With `FILTRO_REBOTE_EN`, `CICLOS_REBOTE=8`: a 5-cycle glitch of code 4 is not captured. A 12-cycle hold is captured exactly once.
